muldiv_unit: RTL and testbench

- Parametrised multi-cycle HI/LO multiply/divide unit that executes MULT, MULTU, DIV and DIVU issued by the decode stage.
- Sits in EXE and owns the HI/LO registers.
- Generalises the prior single-cycle HI/LO path to a configurable width, a configurable multiply latency and an iterative divider.
- Provides a busy handshake for pipeline stall, plus flush/abort on exception.

---
 rtl/muldiv_unit_pkg.sv | 8 +
 rtl/muldiv_unit_div_iter.sv | 49 ++++
 rtl/muldiv_unit.sv | 94 +++++++++
 tb/tb_muldiv_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op encodings (match decoder ALU2Op) and FSM state type for the HI/LO muldiv unit
package muldiv_unit_pkg;
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
endpackage

// File: rtl/muldiv_unit_div_iter.sv
// muldiv_unit_div_iter: WIDTH-cycle restoring divider on magnitudes; ports start/abort, dividend/divisor in, next-step quotient/remainder and last-iteration flag out
module muldiv_unit_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [CW-1:0] cnt;
  logic active;
  logic [WIDTH:0] shifted, diff;
  logic ge;
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff = shifted - {1'b0, dvs};
    ge = !diff[WIDTH];
    remainder = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quotient = {quo[WIDTH-2:0], ge};
    last = active && cnt == CW'(WIDTH - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start) begin
      active <= 1'b1;
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
      cnt <= '0;
    end else if (active) begin
      active <= !(abort || last);
      rem <= remainder;
      quo <= quotient;
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle HI/LO multiply/divide (start/op/a/b issue, flush abort, MTHI/MTLO writes; busy/done/div_by_zero/hi/lo out)
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = MUL_LAT > 2 ? $clog2(MUL_LAT) : 1;
  localparam int MC0 = MUL_LAT > 1 ? MUL_LAT - 2 : 0;
  state_t state, state_n;
  logic [WIDTH-1:0] ma, mb, mx, my, abs_a, abs_b, dv_q, dv_r;
  logic [2*WIDTH-1:0] ex, ey, prod;
  logic [CW-1:0] mcnt;
  logic msgn, xsgn, neg_q, neg_r, accept, dzero, mul_fin, div_fin, dv_last, dv_start;
  assign busy = state != IDLE;
  always_comb begin
    accept = start && state == IDLE && !flush;
    dzero = op[1] && b == '0;
    dv_start = accept && op[1] && !dzero;
    abs_a = (op == MD_DIV && a[WIDTH-1]) ? -a : a;
    abs_b = (op == MD_DIV && b[WIDTH-1]) ? -b : b;
    mx = MUL_LAT == 1 ? a : ma;
    my = MUL_LAT == 1 ? b : mb;
    xsgn = MUL_LAT == 1 ? op == MD_MULT : msgn;
    ex = {{WIDTH{xsgn & mx[WIDTH-1]}}, mx};
    ey = {{WIDTH{xsgn & my[WIDTH-1]}}, my};
    prod = ex * ey;
    mul_fin = MUL_LAT == 1 ? accept && !op[1] : state == MUL && mcnt == '0 && !flush;
    div_fin = state == DIV && dv_last && !flush;
    state_n = state == IDLE ? (dv_start ? DIV : (accept && !op[1] && MUL_LAT > 1) ? MUL : IDLE)
            : (flush || (state == MUL && mcnt == '0) || (state == DIV && dv_last)) ? IDLE : state;
  end
  muldiv_unit_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(dv_start),
    .abort(flush),
    .dividend(abs_a),
    .divisor(abs_b),
    .quotient(dv_q),
    .remainder(dv_r),
    .last(dv_last)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      ma <= '0;
      mb <= '0;
      msgn <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      mcnt <= '0;
    end else begin
      state <= state_n;
      done <= mul_fin || div_fin || (accept && dzero);
      div_by_zero <= accept && dzero;
      if (accept) begin
        ma <= a;
        mb <= b;
        msgn <= op == MD_MULT;
        neg_q <= op == MD_DIV && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= op == MD_DIV && a[WIDTH-1];
        mcnt <= CW'(MC0);
      end else if (state == MUL) mcnt <= mcnt - 1'b1;
      if (state == IDLE && hi_we) hi <= wdata;
      if (state == IDLE && lo_we) lo <= wdata;
      if (mul_fin) {hi, lo} <= prod;
      if (div_fin) begin
        lo <= neg_q ? -dv_q : dv_q;
        hi <= neg_r ? -dv_r : dv_r;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and directed checks of muldiv_unit at WIDTH=32, MUL_LAT=2
module tb_muldiv_unit;
  localparam int W = 32;
  localparam int ML = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] hi, lo;
  int checks = 0, errors = 0;
  logic [W-1:0] exp_hi, exp_lo;
  typedef struct {
    logic [1:0] op;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;
  vec_t tv[12];
  always #5 clk = ~clk;
  muldiv_unit #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz, input int inj);
    int lat, got;
    logic busy_ok;
    lat = o[1] ? (y == '0 ? 1 : W + 1) : ML;
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
    got = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= lat + 5; c++) begin
      if (done) begin
        got = c;
        break;
      end
      if (busy !== (c < lat)) busy_ok = 1'b0;
      if (c == inj) begin
        start = 1'b1; op = 2'b00; a = 3; b = 5;
      end
      tick();
      start = 1'b0;
    end
    chk({name, " done_cycle"}, 64'(got), 64'(lat));
    chk({name, " busy_window"}, 64'(busy_ok), 64'd1);
    chk({name, " busy_at_done"}, 64'(busy), 64'd0);
    chk({name, " hi"}, 64'(hi), 64'(eh));
    chk({name, " lo"}, 64'(lo), 64'(el));
    chk({name, " div_by_zero"}, 64'(div_by_zero), 64'(edz));
    exp_hi = eh;
    exp_lo = el;
    tick();
    chk({name, " done_pulse"}, 64'(done), 64'd0);
  endtask
  initial begin
    logic seen;
    tv[0]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tv[1]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    tv[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tv[3]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tv[4]  = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tv[5]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[6]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tv[7]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
    tv[8]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tv[9]  = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    tv[10] = '{2'b10, 32'd5,        32'd10,       32'd5,        32'd0};
    tv[11] = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    tick();
    tick();
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    lo_we = 1'b1; wdata = 32'hA5A5A5A5;
    tick();
    lo_we = 1'b0;
    chk("mtlo lo", 64'(lo), 64'hA5A5A5A5);
    chk("mtlo hi", 64'(hi), 64'd0);
    hi_we = 1'b1; wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
    chk("mthi hi", 64'(hi), 64'h1234);
    run_op("divu_zero", 2'b10, 32'd100, 32'd0, 32'h1234, 32'hA5A5A5A5, 1'b1, 0);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5A5A0F0F;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo hi", 64'(hi), 64'h5A5A0F0F);
    chk("mthi_mtlo lo", 64'(lo), 64'h5A5A0F0F);
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), tv[i].op, tv[i].a, tv[i].b, tv[i].hi, tv[i].lo, 1'b0, 0);
    run_op("div_ignore_start", 2'b11, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 3);
    chk("ignored start stays idle", 64'(busy), 64'd0);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("flush busy before", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy after", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("flush no done", 64'(seen), 64'd0);
    chk("flush hi kept", 64'(hi), 64'(exp_hi));
    chk("flush lo kept", 64'(lo), 64'(exp_lo));
    run_op("multu_after_flush", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 0);
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("start_flush busy", 64'(busy), 64'd0);
    tick();
    chk("start_flush done", 64'(done), 64'd0);
    chk("start_flush lo", 64'(lo), 64'd15);
    start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7; hi_we = 1'b1; wdata = 32'hDEAD;
    tick();
    start = 1'b0; hi_we = 1'b0;
    chk("accept mthi hi", 64'(hi), 64'hDEAD);
    chk("accept mthi busy", 64'(busy), 64'd1);
    tick();
    chk("accept mthi done", 64'(done), 64'd1);
    chk("accept mthi result hi", 64'(hi), 64'd0);
    chk("accept mthi result lo", 64'(lo), 64'd42);
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done || busy) seen = 1'b1;
      tick();
    end
    chk("rst no done", 64'(seen), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
